// File: rtl/aes_pkg.sv
// Shared AES helpers: S-box tables, GF(2^8) arithmetic, round constants and FSM encoding.
package aes_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StKexp  = 3'd1,
        StReady = 3'd2,
        StRun   = 3'd3,
        StDone  = 3'd4
    } fsm_e;

    // Byte i of each table lives at bits [2047-8*i -: 8].
    localparam logic [2047:0] SboxTable = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] InvSboxTable = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    localparam logic [31:0] InvMixCoef = 32'h0e0b0d09;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SboxTable[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return InvSboxTable[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
module inv_round
    import aes_pkg::*;
(
    input  logic [0:127] state,
    input  logic [0:127] rkey,
    input  logic         last,
    output logic [0:127] state_out
);

    logic [0:127] ark;
    logic [7:0]   acc;

    always_comb begin
        ark       = '0;
        state_out = '0;
        acc       = '0;
        // Row r is rotated right by r columns, so out[r][c] takes in[r][c-r].
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                ark[8 * (4 * c + r) +: 8] =
                    inv_sbox(state[8 * (4 * ((c - r + 4) % 4) + r) +: 8])
                    ^ rkey[8 * (4 * c + r) +: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(InvMixCoef[31 - 8 * ((k - r + 4) % 4) -: 8],
                                     ark[8 * (4 * c + k) +: 8]);
                end
                state_out[8 * (4 * c + r) +: 8] = last ? ark[8 * (4 * c + r) +: 8] : acc;
            end
        end
    end

endmodule

// File: rtl/aes128_inv_cipher_iter.sv
// Iterative AES-128 decryptor: one inverse round per clock, round keys regenerated backwards.
module aes128_inv_cipher_iter
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [0:127] key_in,
    input  logic         key_load,
    output logic         key_ready,
    input  logic [0:127] ct_in,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [0:127] pt_out,
    output logic         out_valid,
    input  logic         out_ready
);

    fsm_e         fsm_q, fsm_d;
    logic [0:127] blk_q, blk_d;
    logic [0:127] rk_q, rk_d;
    logic [0:127] lastkey_q, lastkey_d;
    logic [0:127] pt_q, pt_d;
    logic [3:0]   rnd_q, rnd_d;
    logic         out_valid_q, out_valid_d;
    logic         key_ready_q, key_ready_d;

    logic [0:31]  w0, w1, w2, w3, w1n, w2n, w3n;
    logic [0:31]  sub_in, rot, sub_word, rc, fwd_w0;
    logic [0:127] fwd_key, inv_key, round_out;

    // The four S-boxes serve both schedules: forward uses w3, inverse uses the recovered w3'.
    always_comb begin
        w0       = rk_q[0 +: 32];
        w1       = rk_q[32 +: 32];
        w2       = rk_q[64 +: 32];
        w3       = rk_q[96 +: 32];
        w1n      = w1 ^ w0;
        w2n      = w2 ^ w1;
        w3n      = w3 ^ w2;
        sub_in   = (fsm_q == StRun) ? w3n : w3;
        rot      = {sub_in[8:31], sub_in[0:7]};
        sub_word = {sbox(rot[0:7]), sbox(rot[8:15]), sbox(rot[16:23]), sbox(rot[24:31])};
        rc       = {rcon(rnd_q), 24'h0};
        fwd_w0   = w0 ^ sub_word ^ rc;
        fwd_key  = {fwd_w0, w1 ^ fwd_w0, w2 ^ w1 ^ fwd_w0, w3 ^ w2 ^ w1 ^ fwd_w0};
        inv_key  = {w0 ^ sub_word ^ rc, w1n, w2n, w3n};
    end

    inv_round u_inv_round (
        .state     (blk_q),
        .rkey      (inv_key),
        .last      (rnd_q == 4'd1),
        .state_out (round_out)
    );

    always_comb begin
        fsm_d     = fsm_q;
        blk_d     = blk_q;
        rk_d      = rk_q;
        lastkey_d = lastkey_q;
        pt_d      = pt_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        case (fsm_q)
            StIdle: begin
                if (key_load) begin
                    rk_d  = key_in;
                    rnd_d = 4'd1;
                    fsm_d = StKexp;
                end
            end
            StKexp: begin
                rk_d  = fwd_key;
                rnd_d = rnd_q + 4'd1;
                if (rnd_q == 4'd10) begin
                    lastkey_d = fwd_key;
                    fsm_d     = StReady;
                end
            end
            StReady: begin
                in_ready = !key_load;
                if (key_load) begin
                    rk_d  = key_in;
                    rnd_d = 4'd1;
                    fsm_d = StKexp;
                end else if (in_valid) begin
                    blk_d = ct_in ^ lastkey_q;
                    rk_d  = lastkey_q;
                    rnd_d = 4'd10;
                    fsm_d = StRun;
                end
            end
            StRun: begin
                rk_d  = inv_key;
                blk_d = round_out;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    pt_d  = round_out;
                    fsm_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) fsm_d = StReady;
            end
            default: fsm_d = StIdle;
        endcase
        out_valid_d = (fsm_d == StDone);
        key_ready_d = (fsm_d == StReady);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q       <= StIdle;
            blk_q       <= '0;
            rk_q        <= '0;
            lastkey_q   <= '0;
            pt_q        <= '0;
            rnd_q       <= '0;
            out_valid_q <= 1'b0;
            key_ready_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            blk_q       <= blk_d;
            rk_q        <= rk_d;
            lastkey_q   <= lastkey_d;
            pt_q        <= pt_d;
            rnd_q       <= rnd_d;
            out_valid_q <= out_valid_d;
            key_ready_q <= key_ready_d;
        end
    end

    assign pt_out    = pt_q;
    assign out_valid = out_valid_q;
    assign key_ready = key_ready_q;

endmodule
